// File: rtl/triage_pkg.sv
// Shared types and constants for the triage dispatcher: FSM states,
// patient word layout and queue command encodings.
package triage_pkg;

   localparam int unsigned PAT_W = 4;

   localparam int unsigned PRIO_HI = 3;
   localparam int unsigned PRIO_LO = 2;
   localparam int unsigned ID_HI   = 1;
   localparam int unsigned ID_LO   = 0;

   localparam logic ENDE_ENQ = 1'b0;
   localparam logic ENDE_DEQ = 1'b1;

   typedef logic [PAT_W-1:0] patient_t;

   typedef enum logic [2:0] {
      IDLE,
      ENQ,
      DEQ,
      WAIT_OUT,
      DISPATCH
   } state_t;

   function automatic patient_t mk_patient(input logic [1:0] prio, input logic [1:0] id);
      patient_t p;
      p = '0;
      p[PRIO_HI:PRIO_LO] = prio;
      p[ID_HI:ID_LO]     = id;
      return p;
   endfunction

endpackage

// File: rtl/doc_timer.sv
// Per-doctor service timer: loads SERVICE_CYCLES on dispatch and counts
// down to zero; the doctor is busy while the count is nonzero.
module doc_timer #(
   parameter int unsigned SERVICE_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic busy
);

   localparam logic [7:0] LOAD_VAL = 8'(SERVICE_CYCLES);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (count != '0) begin
         count <= count - 8'd1;
      end
   end

   assign busy = (count != '0);

endmodule

// File: rtl/triage_dispatcher.sv
// Sole master of the patient queue: enqueues arrivals, dequeues when a doctor
// is free and dispatches to the lowest-numbered free doctor. TRIAGE_BYPASS_EN
// lets an arrival skip an empty queue and dispatch directly.
module triage_dispatcher
   import triage_pkg::*;
#(
   parameter int unsigned NUM_DOC        = 2,
   parameter int unsigned SERVICE_CYCLES = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arr_valid,
   input  logic [3:0]         arr_data,
   output logic               arr_ready,
   output logic               q_valid,
   output logic               q_ende,
   output logic [3:0]         q_in,
   input  logic [3:0]         q_out,
   input  logic               q_isfull,
   input  logic               q_isempty,
   output logic               dispatch_valid,
   output logic [3:0]         dispatch_patient,
   output logic [1:0]         dispatch_doc,
   output logic [NUM_DOC-1:0] doc_busy
);

   state_t             state;
   patient_t           arr_r;
   patient_t           patient;
   logic               any_free;
   logic [1:0]         free_idx;
   logic [NUM_DOC-1:0] load;
   logic               start_deq;
   logic               start_enq;
   logic               start_byp;

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int unsigned i = 0; i < NUM_DOC; i++) begin
         if (!doc_busy[i] && !any_free) begin
            any_free = 1'b1;
            free_idx = 2'(i);
         end
      end
   end

   // Dequeue wins over any arrival; bypass (if built) wins over a plain enqueue.
   assign start_deq = (state == IDLE) && any_free && !q_isempty;
`ifdef TRIAGE_BYPASS_EN
   assign start_byp = (state == IDLE) && arr_valid && q_isempty && any_free;
`else
   assign start_byp = 1'b0;
`endif
   assign start_enq = (state == IDLE) && arr_valid && !q_isfull && !start_deq;
   assign arr_ready = start_byp || start_enq;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         arr_r   <= '0;
         patient <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_deq) begin
                  state <= DEQ;
               end else if (start_byp) begin
                  patient <= arr_data;
                  state   <= DISPATCH;
               end else if (start_enq) begin
                  arr_r <= arr_data;
                  state <= ENQ;
               end
            end
            ENQ:      state <= IDLE;
            DEQ:      state <= WAIT_OUT;
            WAIT_OUT: begin
               patient <= q_out;
               state   <= DISPATCH;
            end
            DISPATCH: state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   assign q_valid          = (state == ENQ) || (state == DEQ);
   assign q_ende           = (state == DEQ) ? ENDE_DEQ : ENDE_ENQ;
   assign q_in             = arr_r;
   assign dispatch_valid   = (state == DISPATCH);
   assign dispatch_patient = patient;
   // Free doctor is re-picked in DISPATCH; timers only count down, so one exists.
   assign dispatch_doc     = dispatch_valid ? free_idx : '0;

   always_comb begin
      load = '0;
      for (int unsigned i = 0; i < NUM_DOC; i++) begin
         load[i] = dispatch_valid && (32'(free_idx) == i);
      end
   end

   for (genvar g = 0; g < NUM_DOC; g++) begin : g_doc
      doc_timer #(
         .SERVICE_CYCLES(SERVICE_CYCLES)
      ) u_timer (
         .clk  (clk),
         .rst  (rst),
         .load (load[g]),
         .busy (doc_busy[g])
      );
   end

endmodule

// File: doc/triage_dispatcher.md
# triage_dispatcher

Drives the patient priority queue from the other side. It accepts patient arrivals from the admission desk and issues enqueue commands. It watches a bank of doctor service timers and, when a doctor is free, issues a dequeue command. The dequeued highest-priority patient is then dispatched to the lowest-numbered free doctor. It is the sole master of the queue's command interface and sits between admission logic and the room's priority queue.

## Interface
- NUM_DOC, default 2: number of doctors, 1..4.
- SERVICE_CYCLES, default 8: cycles a doctor stays busy per patient, 1..255.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- arr_valid  in  1  arrival present.
- arr_data  in  4  arrival patient: [3:2] priority (3 = most urgent), [1:0] unique ID.
- arr_ready  out  1  arrival accepted this cycle when arr_valid && arr_ready.
- q_valid  out  1  one-cycle command strobe to queue.
- q_ende  out  1  command type: 0 = enqueue, 1 = dequeue.
- q_in  out  4  patient word for enqueue.
- q_out  in  4  dequeued patient, valid exactly one cycle after a dequeue strobe.
- q_isfull  in  1  queue at capacity.
- q_isempty  in  1  queue holds no patients.
- dispatch_valid  out  1  one-cycle pulse: patient assigned.
- dispatch_patient  out  4  assigned patient word.
- dispatch_doc  out  2  index of assigned doctor.
- doc_busy  out  NUM_DOC  per-doctor busy flags.

## Operation
- States: IDLE, ENQ, DEQ, WAIT_OUT, DISPATCH.
- IDLE: dequeue takes precedence. A dequeue is started when any doctor is free and !q_isempty, going to DEQ. Otherwise an arrival is considered. With arr_valid && !q_isfull, arr_ready is high and the FSM goes to ENQ.
- arr_ready is high only in IDLE, only with !q_isfull, and only when no dequeue is being started that cycle. A full queue backpressures arrivals with no drop. arr_data must be held stable while stalled.
- ENQ: q_valid=1, q_ende=0, q_in = captured arrival. Next state is IDLE.
- DEQ: q_valid=1, q_ende=1. Next state is WAIT_OUT.
- WAIT_OUT: capture q_out into the patient register. Next state is DISPATCH.
- DISPATCH: dispatch_valid=1 with the captured patient and the lowest-index free doctor. That doctor's timer loads SERVICE_CYCLES. Next state is IDLE.
- Doctor timer: 8-bit down-counter. doc_busy = (count != 0). It decrements by 1 per cycle while nonzero and saturates at 0.
- The free doctor is re-evaluated in DISPATCH. A doctor reserved at DEQ cannot be lost, because timers only decrement.
- q_isempty or q_isfull changes mid-transaction are ignored. They are sampled only in IDLE.
- Reset mid-operation: the FSM returns to IDLE, the in-flight patient is discarded, and all timers clear. The queue's own contents are not this block's responsibility.

## Timing
- Reset values: arr_ready=0, q_valid=0, q_ende=0, q_in=0, dispatch_valid=0, dispatch_patient=0, dispatch_doc=0, doc_busy=0.
- All outputs are registered or decoded from the registered state. There are no combinational in-to-out paths except arr_ready, which depends on q_isfull and arr_valid.
- Enqueue: acceptance at cycle N, q_valid at N+1, back in IDLE at N+2.
- Dequeue to dispatch: DEQ at N+1, WAIT_OUT at N+2, dispatch_valid at N+3.
- Minimum enqueue spacing is 2 cycles. Minimum dispatch spacing is 4 cycles.
- doc_busy rises the cycle after dispatch_valid. It falls SERVICE_CYCLES cycles after that.

## Configuration
- TRIAGE_BYPASS_EN defined:
  - Condition: in IDLE, arr_valid && q_isempty && a doctor is free.
  - The arrival is accepted (arr_ready=1) and the FSM goes directly to DISPATCH with arr_data.
  - No queue command is issued, so latency is 1 cycle from acceptance to dispatch_valid.
- TRIAGE_BYPASS_EN undefined: every patient goes through the ENQ/DEQ/WAIT_OUT path.

## Structure
- Package triage_pkg holds:
  - the state enum;
  - field constants PRIO_HI=3, PRIO_LO=2, ID_HI=1, ID_LO=0;
  - the patient word width 4;
  - the ENDE_ENQ=0 and ENDE_DEQ=1 encodings.
- Sub-module doc_timer (parameter SERVICE_CYCLES; ports clk, rst, load, busy) is instantiated NUM_DOC times in a generate loop.
- The free-doctor priority encoder stays inline.

## Test plan
- Reset, then arr_valid=1, arr_data=4'b1101 with empty queue and no bypass: arr_ready=1 at N. At N+1, q_valid=1, q_ende=0, q_in=4'b1101.
- Queue non-empty, doctors free, model returns q_out=4'b1110 one cycle after the dequeue strobe: dispatch_valid=1, dispatch_patient=4'b1110, dispatch_doc=0 three cycles after acceptance. doc_busy[0] is then high for 8 cycles.
- Both doctors busy with q_isfull=1 and arr_valid held: arr_ready stays 0 and no q_valid occurs. When q_isfull drops, the arrival is enqueued exactly once.
- Doctor 0 busy, doctor 1 free, queue non-empty, simultaneous arrival: the dequeue is issued first and the arrival is stalled. Dispatch goes to dispatch_doc=1, then the arrival is enqueued.
- rst asserted in WAIT_OUT: next cycle all outputs are at reset values, with no dispatch_valid and doc_busy=0.
- With TRIAGE_BYPASS_EN, q_isempty=1, arrival 4'b0011: dispatch_valid the cycle after acceptance, with no q_valid pulse.
